// File: rtl/invsqrt_chk_pkg.sv
// Shared definitions for the InvertSQRoot result checker: FSM states,
// data word width and the default compare tolerance.
package invsqrt_chk_pkg;

    // Checker run state
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } chk_state_t;

    // Width of the InvertSQRoot result word
    localparam int DATA_W = 32;

    // Default maximum |DataOut - expected| in raw bit-pattern units
    localparam int TOL_DEFAULT = 3;

endpackage

// File: rtl/chk_sync_fifo.sv
// Single-clock FIFO holding expected result words.
// Pointers carry an extra wrap bit so full and empty are distinguished
// without a separate occupancy counter. The head word is read
// combinationally so a data beat can be compared in the cycle it arrives;
// at this depth the array maps onto distributed RAM.
// All state advances only when ce is high; flush empties the FIFO and
// takes priority over a push or pop in the same cycle.
module chk_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: reset and flush both return to empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (ce) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (ce && w_push_ok && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/invsqrt_result_checker.sv
// On-chip scoreboard for the InvertSQRoot result stream.
// Expected words are queued in a FIFO; each DataValid beat in RUN pops one
// and compares it to DataOut as an unsigned bit-pattern distance against TOL.
// Optional feature macro: INVSQRT_CHK_FIRST_ERR_EN builds the first-error
// capture registers; without it FirstErrIdx/Got/Exp read as zero.
module invsqrt_result_checker
    import invsqrt_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TOL   = TOL_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              Start,
    input  logic [CNT_W-1:0]  NumSamples,
    input  logic [DATA_W-1:0] ExpIn,
    input  logic              ExpValid,
    output logic              ExpReady,
    input  logic [DATA_W-1:0] DataOut,
    input  logic              DataValid,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic              Overrun,
    output logic [CNT_W-1:0]  SampleCount,
    output logic [CNT_W-1:0]  ErrCount,
    output logic [CNT_W-1:0]  FirstErrIdx,
    output logic [DATA_W-1:0] FirstErrGot,
    output logic [DATA_W-1:0] FirstErrExp
);

    chk_state_t        r_state;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_smp_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_overrun;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_beat;
    logic              w_pop;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_diff;
    logic              w_err;
    logic [CNT_W-1:0]  w_err_cnt_next;
    logic [CNT_W-1:0]  w_smp_cnt_next;
    logic              w_last;

    // Start wins over a beat in the same cycle: the run is being discarded
    assign w_beat   = (r_state == S_RUN) && DataValid && !Start;
    assign ExpReady = (r_state == S_RUN) && !w_full;
    assign w_push   = ExpValid && ExpReady;
    assign w_pop    = w_beat && !w_empty;

    chk_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .flush (Start),
        .push  (w_push),
        .wdata (ExpIn),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // A beat against an empty FIFO compares against zero and always errors
    assign w_exp  = w_empty ? '0 : w_head;
    assign w_diff = (DataOut > w_exp) ? (DataOut - w_exp) : (w_exp - DataOut);
    assign w_err  = w_empty || (w_diff > DATA_W'(TOL));

    assign w_err_cnt_next = (w_err && !(&r_err_cnt)) ? (r_err_cnt + CNT_W'(1))
                                                     : r_err_cnt;
    assign w_smp_cnt_next = r_smp_cnt + CNT_W'(1);
    assign w_last         = (w_smp_cnt_next == r_num);

    // Run-control FSM with counters and registered status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_smp_cnt <= '0;
            r_err_cnt <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else if (ce) begin
            if (Start) begin
                r_num     <= NumSamples;
                r_smp_cnt <= '0;
                r_err_cnt <= '0;
                r_overrun <= 1'b0;
                if (NumSamples == '0) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= 1'b1;
                end else begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            end else if (w_beat) begin
                r_smp_cnt <= w_smp_cnt_next;
                r_err_cnt <= w_err_cnt_next;
                if (w_empty) r_overrun <= 1'b1;
                if (w_last) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_cnt_next == '0) && !(r_overrun || w_empty);
                end
            end
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Pass        = r_pass;
    assign Overrun     = r_overrun;
    assign SampleCount = r_smp_cnt;
    assign ErrCount    = r_err_cnt;

`ifdef INVSQRT_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0]  r_first_idx;
    logic [DATA_W-1:0] r_first_got;
    logic [DATA_W-1:0] r_first_exp;

    // Capture the first error of a run, identified by a zero error count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_first_idx <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else if (ce) begin
            if (Start) begin
                r_first_idx <= '0;
                r_first_got <= '0;
                r_first_exp <= '0;
            end else if (w_beat && w_err && (r_err_cnt == '0)) begin
                r_first_idx <= r_smp_cnt;
                r_first_got <= DataOut;
                r_first_exp <= w_exp;
            end
        end
    end

    assign FirstErrIdx = r_first_idx;
    assign FirstErrGot = r_first_got;
    assign FirstErrExp = r_first_exp;
`else
    assign FirstErrIdx = '0;
    assign FirstErrGot = '0;
    assign FirstErrExp = '0;
`endif

endmodule

// File: doc/invsqrt_result_checker.md
# invsqrt_result_checker

On-chip scoreboard for the `InvertSQRoot` result stream. Buffers expected results, produced by a software model, in a small FIFO. Pops one expected word per `DataValid` beat and compares it with `DataOut` as an unsigned 32-bit bit-pattern difference against a tolerance. Reports sample/error counts and pass/fail, so streaming self-test runs on hardware without file I/O.

## Interface
- `DEPTH`, 16: expected-value FIFO depth (power of 2, ≥2)
- `TOL`, 3: max allowed |DataOut − expected| in raw bit-pattern units
- `CNT_W`, 16: width of counters and of `NumSamples`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `ce`  in  1  clock enable; low → every register holds, no push/pop/compare
- `Start`  in  1  pulse; flushes FIFO, clears counters/flags, enters RUN
- `NumSamples`  in  CNT_W  results to check; sampled on `Start`
- `ExpIn`  in  32  expected result word
- `ExpValid`  in  1  `ExpIn` valid
- `ExpReady`  out  1  FIFO accepts `ExpIn` (state RUN and not full)
- `DataOut`  in  32  result from InvertSQRoot
- `DataValid`  in  1  `DataOut` valid
- `Busy`  out  1  state RUN
- `Done`  out  1  state DONE
- `Pass`  out  1  valid when `Done`: `ErrCount`==0 and `Overrun`==0
- `Overrun`  out  1  sticky: `DataValid` seen with FIFO empty
- `SampleCount`  out  CNT_W  results checked
- `ErrCount`  out  CNT_W  mismatches plus overrun beats, saturating at all-ones
- `FirstErrIdx`, `FirstErrGot`, `FirstErrExp`  out  CNT_W/32/32  index, DUT word and expected word of the first error

## Operation
- FSM IDLE → RUN → DONE.
  - IDLE: initial state after reset.
  - RUN: entered on `Start`. If `NumSamples`==0, the FSM goes straight to DONE instead.
  - DONE: holds until `Start`, which re-enters RUN with fresh state. `Start` in RUN restarts identically.
- Push: `ExpValid && ExpReady` at a `ce` edge.
  - When full, `ExpReady` is low even if a pop occurs in the same cycle.
- Beat: `DataValid` in RUN at a `ce` edge. `DataValid` in IDLE/DONE is ignored.
- Beat with FIFO non-empty:
  - Pop the head.
  - diff = larger − smaller of the unsigned 32-bit words.
  - diff > `TOL` → error.
- Beat with FIFO empty (no bypass, even if a push happens in the same cycle):
  - Set `Overrun` and count an error.
  - Expected word recorded as 0.
- Every beat increments `SampleCount`.
- On the first error of a run, capture the index (`SampleCount` before increment) plus the DUT and expected words.
- The beat that makes `SampleCount`==`NumSamples` moves the FSM to DONE.
- Entries left in the FIFO at DONE are not an error; they are flushed by the next `Start`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `ExpReady`, `Busy`, `Done`, `Pass`, `Overrun` all 0.
  - All counters and capture registers 0.
  - FIFO empty.
- All outputs are registered except `ExpReady`, which is decoded combinationally from state and full.
- Beat at edge N → counters, captures and DONE transition are all visible after edge N. Zero additional latency.
- `Start` at edge N → `Busy`=1 after N. `ExpReady` is high from cycle N+1.
- `Pass` is registered on entry to DONE.
- `ce` low for any span → outputs frozen. No beats or pushes are lost, because none are accepted.
- `rst` low mid-run → full reset on that edge; it overrides `Start` and `ce`.

## Configuration
- `INVSQRT_CHK_FIRST_ERR_EN` defined: first-error capture registers are built.
- Not defined: `FirstErrIdx`/`FirstErrGot`/`FirstErrExp` are tied to 0 and the capture logic is omitted. Counters and `Pass` are unaffected.

## Structure
- Package `invsqrt_chk_pkg`: FSM state enum (IDLE, RUN, DONE), `DATA_W`=32, default `TOL`=3.
- One sub-module, `chk_sync_fifo`: single-clock FIFO with parameterised `DEPTH`, pointers carrying an extra wrap bit, `ce`-gated, synchronous active-low reset, flush input driven by `Start`.

## Test plan
- `NumSamples`=2; push 0x3F800000, 0x3F000000; beats 0x3F800000, 0x3F000002 → `Done`=1, `Pass`=1, `SampleCount`=2, `ErrCount`=0.
- `NumSamples`=1; push 0x3F000000; beat 0x3EFFFFFB (diff 5) → `Pass`=0, `ErrCount`=1, `FirstErrIdx`=0, `FirstErrGot`=0x3EFFFFFB, `FirstErrExp`=0x3F000000.
- `NumSamples`=3; one push only, then 3 beats → `Overrun`=1, `ErrCount`=2, `Pass`=0.
- DEPTH=16: 17 pushes offered → `ExpReady` low after the 16th; the 17th is held until a pop. Simultaneous full push+pop → the push is rejected in that cycle.
- `ce` low for 5 cycles mid-run with `DataValid` high → `SampleCount` unchanged; counting resumes when `ce` returns high.
- `rst` low at sample 7 of 10, then `Start` with `NumSamples`=0 → after reset all outputs are 0; after `Start`, `Done`=1 and `Pass`=1 with `SampleCount`=0.
